// File: rtl/axis_mux_sched_if.sv
// Snoop and control bundle between the packet mux and its scheduler.
// The scheduler side uses the slave modport; the mux/stream side uses master.
interface axis_mux_sched_if #(
  parameter int S_COUNT = 4
) ();
  logic [S_COUNT-1:0]         s_axis_tvalid;
  logic [S_COUNT-1:0]         s_axis_tready;
  logic [S_COUNT-1:0]         s_axis_tlast;
  logic                       enable;
  logic [$clog2(S_COUNT)-1:0] select;
  logic                       busy;

  modport master (
    output s_axis_tvalid, s_axis_tready, s_axis_tlast,
    input  enable, select, busy
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tready, s_axis_tlast,
    output enable, select, busy
  );
endinterface

// File: rtl/axis_mux_sched.sv
// Weighted round-robin scheduler for an AXI4-Stream packet mux; moves select only between packets.
// Define AXIS_MUX_SCHED_STATS_EN to add per-port packet counters (stat_port/stat_count).
module axis_mux_sched #(
  parameter int S_COUNT      = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_mux_sched_if.slave            bus,
  input  logic                       cfg_wr,
  input  logic [$clog2(S_COUNT)-1:0] cfg_port,
  input  logic [WEIGHT_WIDTH-1:0]    cfg_weight
`ifdef AXIS_MUX_SCHED_STATS_EN
  ,
  input  logic [$clog2(S_COUNT)-1:0] stat_port,
  output logic [31:0]                stat_count
`endif
);
  localparam int SEL_W = $clog2(S_COUNT);

  typedef enum logic [1:0] {IDLE, GRANT, PKT} state_t;

  state_t                  state_q, state_d;
  logic                    enable_q, enable_d;
  logic                    busy_q, busy_d;
  logic [SEL_W-1:0]        select_q, select_d;
  logic [SEL_W-1:0]        ptr_q, ptr_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
  logic [WEIGHT_WIDTH-1:0] weight_q [S_COUNT];
  logic [WEIGHT_WIDTH-1:0] weight_d [S_COUNT];

  logic [S_COUNT-1:0]      req;
  logic                    beat, eop;
  logic                    win_found;
  logic [SEL_W-1:0]        win, cand;
  logic [WEIGHT_WIDTH-1:0] win_load, credit_dec;
  logic                    pkt_end, regrant;

  assign req  = bus.s_axis_tvalid;
  assign beat = bus.s_axis_tvalid[select_q] & bus.s_axis_tready[select_q];
  assign eop  = beat & bus.s_axis_tlast[select_q];

  // Search starts just after the last-served port, so that port is checked last.
  always_comb begin
    win_found = 1'b0;
    win       = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= S_COUNT; i++) begin
      cand = SEL_W'((int'(ptr_q) + i) % S_COUNT);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  assign win_load   = (weight_q[win] == '0) ? WEIGHT_WIDTH'(1) : weight_q[win];
  assign credit_dec = (credit_q == '0) ? '0 : credit_q - WEIGHT_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    busy_d   = busy_q;
    select_d = select_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    pkt_end  = 1'b0;
    regrant  = 1'b0;

    unique case (state_q)
      IDLE:  regrant = win_found;
      GRANT: begin
        if (eop) begin
          pkt_end = 1'b1;
        end else if (beat) begin
          state_d = PKT;
          busy_d  = 1'b1;
        end else if (!req[select_q]) begin
          regrant = 1'b1;
        end
      end
      PKT:     pkt_end = eop;
      default: state_d = IDLE;
    endcase

    if (pkt_end) begin
      credit_d = credit_dec;
      busy_d   = 1'b0;
      state_d  = GRANT;
      if (credit_dec == '0) regrant = 1'b1;
    end

    // A re-grant forfeits whatever credit the old port still had.
    if (regrant) begin
      if (win_found) begin
        state_d  = GRANT;
        enable_d = 1'b1;
        select_d = win;
        ptr_d    = win;
        credit_d = win_load;
      end else begin
        state_d  = IDLE;
        enable_d = 1'b0;
        busy_d   = 1'b0;
      end
    end
  end

  // Loads read weight_q, so a write landing with a load only affects the next turn.
  always_comb begin
    weight_d = weight_q;
    if (cfg_wr && (int'(cfg_port) < S_COUNT)) weight_d[cfg_port] = cfg_weight;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      select_q <= '0;
      ptr_q    <= SEL_W'(S_COUNT - 1);
      credit_q <= '0;
      for (int i = 0; i < S_COUNT; i++) weight_q[i] <= WEIGHT_WIDTH'(1);
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      select_q <= select_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      weight_q <= weight_d;
    end
  end

  assign bus.enable = enable_q;
  assign bus.select = select_q;
  assign bus.busy   = busy_q;

`ifdef AXIS_MUX_SCHED_STATS_EN
  logic [31:0] cnt_q [S_COUNT];
  logic [31:0] cnt_d [S_COUNT];
  logic [31:0] stat_count_q, stat_count_d;

  always_comb begin
    cnt_d = cnt_q;
    if (eop && (state_q != IDLE)) cnt_d[select_q] = cnt_q[select_q] + 32'd1;
    stat_count_d = (int'(stat_port) < S_COUNT) ? cnt_q[stat_port] : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S_COUNT; i++) cnt_q[i] <= '0;
      stat_count_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count = stat_count_q;
`endif
endmodule

// File: doc/axis_mux_sched.md
Name: axis_mux_sched

Overview:
Weighted round-robin scheduler that drives the enable/select control of an S_COUNT-input AXI4-Stream packet mux.
- Snoops each input's tvalid/tready/tlast to track packet boundaries.
- Grants each requesting port up to weight[port] packets per turn, then moves to the next requesting port.
- Switches select only between packets, so no frame is split or duplicated.

Parameters:
- S_COUNT, 4, number of mux inputs (>=2).
- WEIGHT_WIDTH, 4, width of per-port weight (packets per turn).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- s_axis_tvalid  input  S_COUNT  snooped input tvalid of the mux.
- s_axis_tready  input  S_COUNT  snooped input tready of the mux.
- s_axis_tlast  input  S_COUNT  snooped input tlast of the mux.
- cfg_wr  input  1  weight write strobe.
- cfg_port  input  $clog2(S_COUNT)  port index for the weight write.
- cfg_weight  input  WEIGHT_WIDTH  weight value; 0 is treated as 1.
- enable  output  1  mux enable, registered.
- select  output  $clog2(S_COUNT)  mux select, registered.
- busy  output  1  high while in the PKT state.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - State = IDLE, enable=0, select=0, busy=0, credit=0.
  - All weights = 1; last-served pointer = S_COUNT-1.
- Definitions:
  - beat: s_axis_tvalid[select] & s_axis_tready[select].
  - eop: beat & s_axis_tlast[select].
  - req: s_axis_tvalid (per-port request vector).
- RR search: first set bit of req, starting at (pointer+1) mod S_COUNT, wrapping through all S_COUNT ports (pointer's own port checked last).
- State IDLE:
  - enable=0.
  - On any req: select <= RR winner, credit <= max(weight[winner],1), pointer <= winner, go to GRANT.
  - Latency: enable/select valid 1 cycle after req is first seen.
- State GRANT:
  - enable=1, waiting for the first beat.
  - eop (single-beat packet): handle as packet end (below).
  - beat without tlast: go to PKT.
  - No beat and req[select]=0:
    - If another port is requesting: re-grant to the RR winner (remaining credit forfeited).
    - If no port is requesting: go to IDLE, enable <= 0.
  - Once req[select] is high it is held until the beat (AXIS rule), so the grant never moves under a started frame.
- State PKT:
  - enable=1, select frozen, busy=1.
  - Stays until eop.
- Packet end (on the eop clock edge):
  - credit <= credit-1.
  - If new credit != 0: stay on the same port, go to GRANT.
  - If new credit == 0 and RR finds a requester: registered update of select to the winner, credit reload, go to GRANT.
  - If new credit == 0 and no requester: go to IDLE, enable <= 0.
  - The update is registered, so the mux sees the new enable/select on the first cycle its frame flag is clear. No extra frame starts on the old port.
- Credit: WEIGHT_WIDTH bits; no wrap.
  - Loaded only at grant time.
  - Decrements only on eop.
  - Never underflows below 0.
- Config writes:
  - cfg_wr with cfg_port >= S_COUNT is ignored.
  - Writes take effect at the next credit load; the current turn is unaffected.
  - A write in the same cycle as a load to the same port: the load uses the old weight.
- Reset mid-packet: all state returns to reset values next cycle and enable drops. Draining the mux is the system reset's responsibility.

Optional Feature:
Macro AXIS_MUX_SCHED_STATS_EN.
- Defined:
  - Adds ports stat_port (input, $clog2(S_COUNT)) and stat_count (output, 32).
  - Per-port 32-bit packet counters increment on each eop of the granted port and wrap at 2^32-1 -> 0.
  - stat_count is a registered read of counter[stat_port]; 1-cycle latency; 0 if stat_port >= S_COUNT.
  - Counters clear on rst.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset, then req=4'b0001 -> next cycle enable=1, select=0. 3 single-beat packets on port 0 with weight 1 -> select stays 0 (only requester). req=0 after the last eop -> enable=0, state IDLE.
- Weights {1,2,1,1}, ports 0-3 all continuously requesting 1-beat packets -> grant sequence 0,1,1,2,3,0 with each switch 1 cycle after the eop edge.
- Port 2 granted, multi-beat packet (5 beats, tready toggling) while port 3 requests -> select stays 2 and busy=1 until the tlast beat; select=3 on the following cycle.
- Port 1 granted with credit 3, sends 1 packet, then drops tvalid while port 0 requests -> re-grant to port 0 (next in RR after pointer 1 is 2,3,0). Port 1's remaining credit is forfeited.
- cfg_wr port 1 weight 0 -> port 1 gets 1 packet per turn. cfg_port=5 with S_COUNT=4 -> no weight changes.
- rst asserted during PKT on port 3 -> next cycle enable=0, select=0, busy=0. With AXIS_MUX_SCHED_STATS_EN, stat_count=0 for all ports after reset; after 7 eops on port 1, stat_port=1 -> stat_count=7 one cycle later.
